mdma_axi_write_engine: RTL
==========================

Name: mdma_axi_write_engine

Overview:
- Parametrised AXI write-channel DMA engine; next generation of the single-burst write mover in the Mdma datapath.
- Accepts one command (start address, total beat count) and splits it into INCR bursts of at most MAX_BURST beats, never crossing a 4 KB boundary.
- Streams write data from a first-word-fall-through FIFO and tracks up to MAX_OUTSTANDING write responses.
- Reports completion and a sticky error flag per command.

Parameters:
- DATA_W, 64, AXI data width in bits (power of 2, 32..512)
- ADDR_W, 32, AXI address width
- LEN_W, 8, awlen width (4 for AXI3, 8 for AXI4)
- MAX_BURST, 16, maximum beats per burst, 1..2^LEN_W
- BEATS_W, 16, width of the command beat count
- MAX_OUTSTANDING, 4, maximum bursts awaiting a B response, 1..15

Ports:
- aclk  in  1  clock
- areset  in  1  asynchronous active-low reset
- cmd_valid  in  1  command request
- cmd_ready  out  1  engine idle, command accepted on cmd_valid&&cmd_ready
- cmd_addr  in  ADDR_W  start byte address; low log2(DATA_W/8) bits ignored (forced 0)
- cmd_beats  in  BEATS_W  total beats to write
- done  out  1  one-cycle pulse when the command is fully retired
- err  out  1  valid with done; 1 if any bresp[1] was set during the command
- fifo_empty  in  1  FWFT FIFO empty
- fifo_rdata  in  DATA_W  FWFT FIFO head word
- fifo_ren  out  1  pop FIFO head
- awaddr  out  ADDR_W; awlen  out  LEN_W; awsize  out  3 (constant log2(DATA_W/8)); awburst  out  2 (constant 2'b01); awvalid  out  1; awready  in  1
- wdata  out  DATA_W; wstrb  out  DATA_W/8 (all ones); wlast  out  1; wvalid  out  1; wready  in  1
- bresp  in  2; bvalid  in  1; bready  out  1 (constant 1)

Behaviour:
- Reset (areset low, asynchronous): state IDLE; cmd_ready=1; awvalid=0, wvalid=0, done=0, err=0, awaddr=0, awlen=0; all counters 0. Reset mid-command abandons the transfer with no further AXI activity.
- States: IDLE, ADDR, DATA, DRAIN, FIN.
- IDLE: cmd_ready=1. On accept, latch address (aligned) and remaining=cmd_beats and clear the sticky error. cmd_beats==0 -> FIN; otherwise -> ADDR.
- ADDR burst length: blen = min(MAX_BURST, remaining, (4096 - addr[11:0]) / (DATA_W/8)).
  - Register awaddr=addr, awlen=blen-1 and assert awvalid the cycle after entering ADDR, but only if outstanding < MAX_OUTSTANDING; otherwise hold with awvalid=0.
  - awaddr/awlen stay stable while awvalid=1.
  - On awvalid&&awready: awvalid<=0; beat_cnt=blen; addr += blen*DATA_W/8; remaining -= blen; -> DATA.
- DATA: wvalid = !fifo_empty (combinational); wdata=fifo_rdata; fifo_ren = wvalid&&wready; wlast = (beat_cnt==1).
  - Each handshake decrements beat_cnt.
  - Handshake with wlast: outstanding += 1; remaining>0 -> ADDR, else -> DRAIN.
  - wvalid is never asserted outside DATA.
- DRAIN: wait until outstanding==0, then -> FIN.
- FIN: done=1 and err=sticky for exactly one cycle -> IDLE. cmd_ready is 0 in FIN.
- Outstanding counter: +1 on the wlast handshake, -1 on bvalid. A simultaneous increment and decrement leaves it unchanged. A B response arriving when outstanding==0 is ignored.
- Sticky error: set by any bvalid with bresp[1]=1 (SLVERR/DECERR); cleared on command accept.
- Address arithmetic is modulo 2^ADDR_W. A burst never straddles a 4 KB boundary.
- Latency: minimum two cycles from command accept to the first awvalid.

Optional Feature:
- Macro MDMA_WR_STATS_EN.
- Defined: adds outputs stat_bursts (16 bits, bursts issued), stat_wstall (16 bits, DATA cycles with fifo_empty=1 or wready=0), and stat_clr (input, 1 bit) that synchronously zeroes both counters.
  - Counters saturate at 16'hFFFF and are cleared by reset.
  - stat_clr has priority over a same-cycle increment.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Command addr=0x1000, beats=40, MAX_BURST=16, FIFO always non-empty, ready always 1 -> three bursts (awaddr 0x1000/0x1080/0x1100, awlen 15/15/7), 40 fifo_ren pulses, wlast on beats 16/32/40, done=1 with err=0.
- Command addr=0x0FF0, beats=8, DATA_W=64 -> bursts at 0x0FF0 (awlen 1) then 0x1000 (awlen 5); no 4 KB crossing.
- bvalid held off, MAX_OUTSTANDING=2, beats=64 -> third awvalid stays low until the first bvalid; done only after all 4 B responses.
- Second B response returns bresp=2'b10 -> done with err=1; the next command (beats=4) returns err=0.
- Command beats=0 -> done one cycle after FIN entry, no awvalid/wvalid; also toggle fifo_empty and wready randomly on beats=20 -> data order preserved, exactly 20 pops.
- Assert areset low mid-DATA -> awvalid, wvalid and done drop immediately, cmd_ready=1 after release; with MDMA_WR_STATS_EN, stat_bursts==0 after reset.

Source files
------------

// File: rtl/mdma_axi_write_engine.sv
// mdma_axi_write_engine: splits a write command into 4KB-safe INCR bursts fed from a FWFT FIFO.
// Optional burst/stall statistics ports are enabled with `define MDMA_WR_STATS_EN.
module mdma_axi_write_engine #(
  parameter int DATA_W          = 64,
  parameter int ADDR_W          = 32,
  parameter int LEN_W           = 8,
  parameter int MAX_BURST       = 16,
  parameter int BEATS_W         = 16,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                  aclk,
  input  logic                  areset,
`ifdef MDMA_WR_STATS_EN
  input  logic                  stat_clr,
  output logic [15:0]           stat_bursts,
  output logic [15:0]           stat_wstall,
`endif
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [ADDR_W-1:0]     cmd_addr,
  input  logic [BEATS_W-1:0]    cmd_beats,
  output logic                  done,
  output logic                  err,
  input  logic                  fifo_empty,
  input  logic [DATA_W-1:0]     fifo_rdata,
  output logic                  fifo_ren,
  output logic [ADDR_W-1:0]     awaddr,
  output logic [LEN_W-1:0]      awlen,
  output logic [2:0]            awsize,
  output logic [1:0]            awburst,
  output logic                  awvalid,
  input  logic                  awready,
  output logic [DATA_W-1:0]     wdata,
  output logic [DATA_W/8-1:0]   wstrb,
  output logic                  wlast,
  output logic                  wvalid,
  input  logic                  wready,
  input  logic [1:0]            bresp,
  input  logic                  bvalid,
  output logic                  bready
);
  localparam int BYTES = DATA_W / 8;
  localparam int BSH   = $clog2(BYTES);
  localparam int CW    = LEN_W + 1;
  typedef enum logic [2:0] {IDLE, ADDR, DATA, DRAIN, FIN} state_t;
  state_t              state_q;
  logic [ADDR_W-1:0]   addr_q, awaddr_q;
  logic [LEN_W-1:0]    awlen_q;
  logic [BEATS_W-1:0]  rem_q;
  logic [CW-1:0]       beat_q;
  logic [3:0]          out_q, out_d;
  logic                awvalid_q, cmd_ready_q, done_q, err_q, sticky_q;
  logic [31:0]         room, blen;
  logic                w_hs, inc, dec;
  logic                unused_bresp0;
  // burst length limited by MAX_BURST, remaining beats and room left in the 4KB page
  always_comb begin
    room = (32'd4096 - 32'(addr_q[11:0])) >> BSH;
    blen = (32'(MAX_BURST) < 32'(rem_q)) ? 32'(MAX_BURST) : 32'(rem_q);
    blen = (room < blen) ? room : blen;
  end
  assign wvalid   = (state_q == DATA) && !fifo_empty;
  assign wlast    = (state_q == DATA) && (beat_q == CW'(1));
  assign w_hs     = wvalid && wready;
  assign fifo_ren = w_hs;
  assign inc      = w_hs && wlast;
  assign dec      = bvalid && (out_q != 4'd0);
  assign out_d    = out_q + 4'(inc) - 4'(dec);
  assign wdata    = fifo_rdata;
  assign wstrb    = '1;
  assign awaddr   = awaddr_q;
  assign awlen    = awlen_q;
  assign awvalid  = awvalid_q;
  assign awsize   = 3'(BSH);
  assign awburst  = 2'b01;
  assign bready   = 1'b1;
  assign cmd_ready = cmd_ready_q;
  assign done     = done_q;
  assign err      = err_q;
  assign unused_bresp0 = bresp[0];
  always_ff @(posedge aclk or negedge areset) begin
    if (!areset) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      awaddr_q    <= '0;
      awlen_q     <= '0;
      rem_q       <= '0;
      beat_q      <= '0;
      out_q       <= '0;
      awvalid_q   <= 1'b0;
      cmd_ready_q <= 1'b1;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      sticky_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      out_q  <= out_d;
      if (dec && bresp[1]) sticky_q <= 1'b1;
      case (state_q)
        IDLE: if (cmd_valid) begin
          cmd_ready_q <= 1'b0;
          addr_q      <= cmd_addr & ~ADDR_W'(BYTES - 1);
          rem_q       <= cmd_beats;
          sticky_q    <= 1'b0;
          state_q     <= (cmd_beats == '0) ? FIN : ADDR;
          done_q      <= (cmd_beats == '0);
        end
        ADDR: if (awvalid_q) begin
          if (awready) begin
            awvalid_q <= 1'b0;
            beat_q    <= CW'(blen);
            addr_q    <= addr_q + ADDR_W'(blen << BSH);
            rem_q     <= rem_q - BEATS_W'(blen);
            state_q   <= DATA;
          end
        end else if (out_q < 4'(MAX_OUTSTANDING)) begin
          awvalid_q <= 1'b1;
          awaddr_q  <= addr_q;
          awlen_q   <= LEN_W'(blen - 32'd1);
        end
        DATA: if (w_hs) begin
          beat_q <= beat_q - CW'(1);
          if (wlast) state_q <= (rem_q != '0) ? ADDR : DRAIN;
        end
        DRAIN: if (out_q == 4'd0) begin
          state_q <= FIN;
          done_q  <= 1'b1;
          err_q   <= sticky_q;
        end
        FIN: begin
          state_q     <= IDLE;
          cmd_ready_q <= 1'b1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
`ifdef MDMA_WR_STATS_EN
  always_ff @(posedge aclk or negedge areset) begin
    if (!areset) begin
      stat_bursts <= '0;
      stat_wstall <= '0;
    end else if (stat_clr) begin
      stat_bursts <= '0;
      stat_wstall <= '0;
    end else begin
      if (awvalid_q && awready && stat_bursts != 16'hFFFF) stat_bursts <= stat_bursts + 16'd1;
      if (state_q == DATA && (fifo_empty || !wready) && stat_wstall != 16'hFFFF) stat_wstall <= stat_wstall + 16'd1;
    end
  end
`endif
endmodule
